// File: rtl/scb_cla32_add_if.sv
// Operand/result bundle for the 32-bit carry-select adder.
// Optional ovf signal present when SCB_CLA32_OVF_EN is defined.
interface scb_cla32_add_if;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        in_valid;
  logic [31:0] s;
  logic        cout;
  logic        out_valid;
`ifdef SCB_CLA32_OVF_EN
  logic        ovf;
`endif

`ifdef SCB_CLA32_OVF_EN
  modport master (output x, y, cin, in_valid, input s, cout, out_valid, ovf);
  modport slave  (input x, y, cin, in_valid, output s, cout, out_valid, ovf);
`else
  modport master (output x, y, cin, in_valid, input s, cout, out_valid);
  modport slave  (input x, y, cin, in_valid, output s, cout, out_valid);
`endif
endinterface

// File: rtl/scb_cla32_add.sv
// 32-bit square-root carry-select adder: CLA groups 2,2,3,4,5,6,7,3 with BEC-1 carry=1 paths,
// one output register stage. SCB_CLA32_OVF_EN adds a registered signed-overflow flag.
module scb_cla32_add (
  input logic              clk,
  input logic              rst_n,
  scb_cla32_add_if.slave   bus
);

  localparam int GrpLo [8] = '{0, 2, 4, 7, 11, 16, 22, 29};
  localparam int GrpW  [8] = '{2, 2, 3, 4, 5, 6, 7, 3};

  // Lookahead add of the low n bits; result packed as {carry, sum} in bits [n:0].
  // Each carry is a flat sum of products over g/p, so no bit waits on its neighbour.
  function automatic logic [7:0] cla(input logic [6:0] a, input logic [6:0] b,
                                     input logic ci, input int n);
    logic [6:0] g;
    logic [6:0] p;
    logic [7:0] c;
    logic [7:0] r;
    logic       t;
    g = a & b;
    p = a ^ b;
    c = '0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      c[i] = ci;
      for (int k = 0; k < 7; k++) begin
        if (k < i) c[i] = c[i] & p[k];
      end
      for (int j = 0; j < 7; j++) begin
        if (j < i) begin
          t = g[j];
          for (int k = 0; k < 7; k++) begin
            if (k > j && k < i) t = t & p[k];
          end
          c[i] = c[i] | t;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i] = p[i] ^ c[i];
      else if (i == n) r[i] = c[i];
    end
    return r;
  endfunction

  logic [31:0] sum_d;
  logic        cout_d;
  logic [31:0] s_q;
  logic        cout_q;
  logic        valid_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int Lo = GrpLo[gi];
    localparam int W  = GrpW[gi];

    logic [6:0] a;
    logic [6:0] b;
    logic [7:0] r0;
    logic [W:0] pk_sel;
    logic       co;

    always_comb begin
      a = '0;
      b = '0;
      a[W-1:0] = bus.x[Lo +: W];
      b[W-1:0] = bus.y[Lo +: W];
    end

    if (gi == 0) begin : g_base
      assign r0     = cla(a, b, bus.cin, W);
      assign pk_sel = r0[W:0];
    end else begin : g_sel
      logic [W:0] pk1;
      assign r0 = cla(a, b, 1'b0, W);
      // BEC-1: {carry0,sum0}+1 via an AND chain feeding XORs.
      always_comb begin : bec1
        logic acc;
        acc = 1'b1;
        for (int i = 0; i <= W; i++) begin
          pk1[i] = r0[i] ^ acc;
          acc    = acc & r0[i];
        end
      end
      assign pk_sel = g_grp[gi-1].co ? pk1 : r0[W:0];
    end

    if (W < 7) begin : g_unused
      logic unused_r0;
      assign unused_r0 = ^r0[7:W+1];
    end

    assign co               = pk_sel[W];
    assign sum_d[Lo +: W]   = pk_sel[W-1:0];
  end

  assign cout_d = g_grp[7].co;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q    <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = valid_q;

`ifdef SCB_CLA32_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (bus.x[31] == bus.y[31]) && (sum_d[31] != bus.x[31]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_scb_cla32_add.sv
// Scoreboard bench for scb_cla32_add: directed vectors push expected results, a negedge
// monitor pops and compares on out_valid and checks hold behaviour otherwise.
module tb_scb_cla32_add;

  logic clk;
  logic rst_n;

  scb_cla32_add_if bus ();

  scb_cla32_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected entry: {ovf, cout, s}.
  logic [33:0] exp_q[$];
  int          n_pass;
  int          n_total;
  logic [31:0] last_s;
  logic        last_cout;
  logic        last_ovf;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    ov   = (a[31] == b[31]) && (full[31] != a[31]);
    return {ov, full};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.x        = a;
    bus.y        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.x        = 32'hDEADBEEF;
    bus.y        = 32'h12345678;
    bus.cin      = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare on out_valid, otherwise outputs must hold the last loaded value.
  always @(negedge clk) begin
    if (rst_n) begin
      logic        ovf_act;
      logic [33:0] e;
`ifdef SCB_CLA32_OVF_EN
      ovf_act = bus.ovf;
`else
      ovf_act = 1'b0;
`endif
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 34'd1, 34'd0);
        end else begin
          e = exp_q.pop_front();
`ifndef SCB_CLA32_OVF_EN
          e[33] = 1'b0;
`endif
          check("sum", {ovf_act, bus.cout, bus.s}, e);
          last_s    = e[31:0];
          last_cout = e[32];
          last_ovf  = e[33];
        end
      end else begin
        check("hold", {ovf_act, bus.cout, bus.s}, {last_ovf, last_cout, last_s});
      end
    end
  end

  initial begin
    n_pass       = 0;
    n_total      = 0;
    last_s       = '0;
    last_cout    = 1'b0;
    last_ovf     = 1'b0;
    rst_n        = 1'b0;
    bus.x        = 32'hFFFFFFFF;
    bus.y        = 32'hFFFFFFFF;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s", {2'b00, bus.s}, 34'd0);
    check("reset_cout_valid", {32'd0, bus.cout, bus.out_valid}, 34'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    idle(1);

    issue(32'h42884743, 32'h42884743, 1'b0);
    issue(32'hF28A47B3, 32'h4B8B47A3, 1'b1);
    issue(32'hF28E47BC, 32'h9B8B47AB, 1'b1);
    idle(3);
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1);
    issue(32'h0000FFFF, 32'h00000001, 1'b0);
    issue(32'h00000003, 32'h00000001, 1'b0);
    issue(32'h0000007F, 32'h00000000, 1'b1);
    issue(32'h1FFFFFFF, 32'h00000001, 1'b0);
    issue(32'hE0000000, 32'h20000000, 1'b0);
    issue(32'h00000000, 32'h00000000, 1'b0);
`ifdef SCB_CLA32_OVF_EN
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
    issue(32'h80000000, 32'h80000000, 1'b0);
    issue(32'h80000000, 32'h7FFFFFFF, 1'b1);
`endif
    idle(2);

    // Back-to-back random stream with occasional bubbles.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    idle(3);

    check("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
